transform_loop_seq: RTL and testbench
=====================================

TRANSFORM_LOOP_SEQ -- requirements
Module: transform_loop_seq

Interface
REQ-001 The block SHALL have parameter IDX_W, default 3, meaning index width per loop variable; block size N = 2**IDX_W.
REQ-002 The block SHALL have parameter RD_LAT, default 1, range 1..4, meaning cycles from read_enable to valid coefficient-memory data.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, which requests a full transform when sampled high in IDLE.
REQ-006 The block SHALL have port abort, input, 1, a synchronous cancel of a running transform.
REQ-007 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the current coefficient.
REQ-008 The block SHALL have ports u, v, input-index outputs, IDX_W each, giving the inner-loop indices of the current issue.
REQ-009 The block SHALL have ports x, y, outputs, IDX_W each, giving the outer-loop coefficient indices.
REQ-010 The block SHALL have port address, output, 2*IDX_W, equal to {u,v} of the current read.
REQ-011 The block SHALL have ports read_enable, mac_en, mac_clr, coef_valid, busy and done, each an output of width 1.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DRAIN and OUT; all outputs are registered.
REQ-013 In IDLE with start=1, the block SHALL enter RUN on the next edge with u=v=0, and x=y=0.
REQ-014 In RUN, read_enable SHALL be 1 and address={u,v} every cycle; v increments each cycle; on v wrap u increments.
REQ-015 After issuing u=v=N-1, the block SHALL enter DRAIN for exactly RD_LAT cycles with read_enable=0.
REQ-016 mac_en SHALL equal read_enable delayed by RD_LAT cycles.
REQ-017 mac_clr SHALL be high only together with the mac_en of the first product (u=v=0) of each coefficient.
REQ-018 In OUT, coef_valid SHALL be 1 and x,y SHALL hold; the block waits indefinitely while out_ready=0.
REQ-019 On OUT with out_ready=1, if x=y=N-1 the block SHALL go to IDLE and pulse done for one cycle; otherwise y increments (wrapping to 0 and incrementing x), u=v=0, and the block returns to RUN.
REQ-020 Loop order, innermost first, SHALL be v, u, y, x; all index arithmetic is modulo N with no overflow flag.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
REQ-024 On abort, read_enable, coef_valid and mac_clr SHALL be cleared and the mac_en pipe flushed, and done SHALL NOT pulse.
REQ-025 abort has priority over out_ready and over start in the same cycle.
REQ-026 out_ready outside OUT SHALL be ignored.
REQ-027 For zero-stall operation, each coefficient SHALL take N*N + RD_LAT + 1 cycles.

Reset
REQ-028 While reset=1, the block SHALL be in IDLE with u, v, x, y and address at 0.
REQ-029 While reset=1, read_enable, mac_en, mac_clr, coef_valid, busy and done SHALL be 0, and the delay pipe SHALL be cleared.
REQ-030 Reset asserted mid-transform SHALL abandon it without a done pulse; the first edge after deassertion SHALL behave as IDLE.

Structure
REQ-031 The state enumeration and the default values of IDX_W and RD_LAT SHALL live in the shared package transform_pkg.
REQ-032 The RD_LAT delay line for read_enable to mac_en SHALL be a sub-module rd_lat_pipe, parametrised by depth, with asynchronous active-high reset.

Verification
REQ-033 Scenario: IDX_W=3, RD_LAT=1, out_ready=1, start pulse -> 4096 reads and 4096 mac_en in total; 64 coef_valid; done one cycle after 4224 cycles.
REQ-034 Scenario: IDX_W=1, RD_LAT=2 -> address sequence 0,1,2,3 per coefficient; 7 cycles per coefficient; mac_clr on the 1st of each 4 mac_en.
REQ-035 Scenario: out_ready=0 for 10 cycles at coefficient (x=0,y=2) -> coef_valid, x and y are held; no read_enable; resumes with address=0 after acceptance.
REQ-036 Scenario: abort at the 30th RUN cycle -> IDLE next cycle; busy=0; done never rises; mac_en=0 within 1 cycle.
REQ-037 Scenario: reset pulse mid-DRAIN -> all outputs 0 asynchronously; a following start runs a full transform from x=y=0.
REQ-038 Scenario: start held high across done -> a second transform begins the cycle after IDLE is reached; start while busy has no effect.

Source files
------------

// File: rtl/transform_pkg.sv
// Shared types and defaults for the transform loop sequencer.
package transform_pkg;

  localparam int unsigned IDX_W_DEF  = 3;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned LAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Per-read tag carried down the memory-latency pipe to the MAC.
  typedef struct packed {
    logic clr;
    logic en;
  } mac_tag_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-depth delay line aligning read tags with coefficient-memory data.
module rd_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    if (!flush) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/transform_loop_seq.sv
// Four-deep loop sequencer (x, y outer / u, v inner) driving coefficient
// memory reads, MAC control and a ready/valid coefficient output.
module transform_loop_seq
  import transform_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     u,
  output logic [IDX_W-1:0]     v,
  output logic [IDX_W-1:0]     x,
  output logic [IDX_W-1:0]     y,
  output logic [2*IDX_W-1:0]   address,
  output logic                 read_enable,
  output logic                 mac_en,
  output logic                 mac_clr,
  output logic                 coef_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IDX_W-1:0]     IDX_MAX  = '1;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LAT - 1);

  state_e state_q, state_d;

  logic [IDX_W-1:0]     u_q, u_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 read_enable_q, read_enable_d;
  logic                 coef_valid_q, coef_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic     issue_last, coef_last;
  mac_tag_t tag_in, tag_out;

  assign issue_last = (u_q == IDX_MAX) && (v_q == IDX_MAX);
  assign coef_last  = (x_q == IDX_MAX) && (y_q == IDX_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Abort overrides every other transition, including start in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (lat_cnt_q == LAT_LAST) state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = coef_last ? ST_IDLE : ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    u_d       = u_q;
    v_d       = v_q;
    x_d       = x_q;
    y_d       = y_q;
    lat_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RUN) begin
          u_d = '0;
          v_d = '0;
          x_d = '0;
          y_d = '0;
        end
      end
      ST_RUN: begin
        v_d = v_q + IDX_W'(1);
        if (v_q == IDX_MAX) u_d = u_q + IDX_W'(1);
      end
      ST_DRAIN: lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
      ST_OUT: begin
        if (out_ready && !coef_last) begin
          y_d = y_q + IDX_W'(1);
          if (y_q == IDX_MAX) x_d = x_q + IDX_W'(1);
          u_d = '0;
          v_d = '0;
        end
      end
      default: ;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      u_d = '0;
      v_d = '0;
      x_d = '0;
      y_d = '0;
    end
    read_enable_d = (state_d == ST_RUN);
    coef_valid_d  = (state_d == ST_OUT);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_q == ST_OUT) && out_ready && coef_last && !abort;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      u_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      lat_cnt_q     <= '0;
      read_enable_q <= 1'b0;
      coef_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      u_q           <= u_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      lat_cnt_q     <= lat_cnt_d;
      read_enable_q <= read_enable_d;
      coef_valid_q  <= coef_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // The first product of every coefficient is the read at u=v=0.
  assign tag_in.en  = read_enable_q;
  assign tag_in.clr = read_enable_q && (u_q == '0) && (v_q == '0);

  rd_lat_pipe #(
    .DEPTH(RD_LAT),
    .WIDTH($bits(mac_tag_t))
  ) u_rd_lat_pipe (
    .clock(clock),
    .reset(reset),
    .flush(abort),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign u           = u_q;
  assign v           = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign address     = {u_q, v_q};
  assign read_enable = read_enable_q;
  assign mac_en      = tag_out.en;
  assign mac_clr     = tag_out.clr;
  assign coef_valid  = coef_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_transform_loop_seq.sv
// Directed bench: an 8x8/RD_LAT=1 instance and a 2x2/RD_LAT=2 instance.
module tb_transform_loop_seq;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       start_a, abort_a, rdy_a;
  logic [2:0] u_a, v_a, x_a, y_a;
  logic [5:0] address_a;
  logic       re_a, me_a, mc_a, cv_a, busy_a, done_a;

  logic       start_b, abort_b, rdy_b;
  logic [0:0] u_b, v_b, x_b, y_b;
  logic [1:0] address_b;
  logic       re_b, me_b, mc_b, cv_b, busy_b, done_b;

  transform_loop_seq #(.IDX_W(3), .RD_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
    .out_ready(rdy_a), .u(u_a), .v(v_a), .x(x_a), .y(y_a),
    .address(address_a), .read_enable(re_a), .mac_en(me_a),
    .mac_clr(mc_a), .coef_valid(cv_a), .busy(busy_a), .done(done_a)
  );

  transform_loop_seq #(.IDX_W(1), .RD_LAT(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
    .out_ready(rdy_b), .u(u_b), .v(v_b), .x(x_b), .y(y_b),
    .address(address_b), .read_enable(re_b), .mac_en(me_b),
    .mac_clr(mc_b), .coef_valid(cv_b), .busy(busy_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hand-derived trace of the 2x2 instance with start held high;
  // s=1 is the first sample after the start edge, 7 samples per coefficient.
  function automatic logic [9:0] exp_b(input int s);
    int k, p;
    logic re, me, mc, cv, bz, dn, xx, yy;
    logic [1:0] ad;
    if (s <= 28) begin
      k  = (s - 1) / 7;
      p  = (s - 1) % 7;
      re = (p < 4);
      ad = re ? 2'(p) : 2'd0;
      me = (p >= 2) && (p <= 5);
      mc = (p == 2);
      cv = (p == 6);
      bz = 1'b1;
      dn = 1'b0;
      xx = (k >= 2);
      yy = (k % 2 == 1);
    end else if (s == 29) begin
      re = 0; ad = 0; me = 0; mc = 0; cv = 0; bz = 0; dn = 1; xx = 1; yy = 1;
    end else begin
      re = 1; ad = 0; me = 0; mc = 0; cv = 0; bz = 1; dn = 0; xx = 0; yy = 0;
    end
    return {xx, yy, ad, re, me, mc, cv, bz, dn};
  endfunction

  initial begin
    int n, cnt_busy, cnt_re, cnt_me, cnt_cv, cnt_clr;
    int addr_exp, addr_err, order_err, clr_err, hold_err, quiet_err;

    reset   = 1'b1;
    start_a = 0; abort_a = 0; rdy_a = 1;
    start_b = 0; abort_b = 0; rdy_b = 1;
    #12;
    chk("rst_a_ctrl", {re_a, me_a, mc_a, cv_a, busy_a, done_a}, 0);
    chk("rst_a_idx",  {u_a, v_a, x_a, y_a, address_a}, 0);
    chk("rst_b_ctrl", {re_b, me_b, mc_b, cv_b, busy_b, done_b}, 0);
    reset = 1'b0;
    step();
    chk("idle_after_rst", {busy_a, re_a}, 0);

    // Full 8x8 transform, consumer always ready.
    start_a = 1; step(); start_a = 0;
    chk("a_first_issue", {re_a, busy_a, address_a}, {1'b1, 1'b1, 6'd0});
    n = 0; cnt_busy = 0; cnt_re = 0; cnt_me = 0; cnt_cv = 0; cnt_clr = 0;
    addr_exp = 0; addr_err = 0; order_err = 0; clr_err = 0;
    while (!done_a && n < 6000) begin
      if (busy_a) cnt_busy++;
      if (re_a) begin
        cnt_re++;
        if (address_a !== 6'(addr_exp)) addr_err++;
        addr_exp = (addr_exp + 1) % 64;
      end
      if (me_a) cnt_me++;
      if (mc_a) begin
        cnt_clr++;
        if (!me_a) clr_err++;
      end
      if (cv_a) begin
        if ({x_a, y_a} !== 6'(cnt_cv)) order_err++;
        cnt_cv++;
      end
      step();
      n++;
    end
    chk("a_done_seen",   {done_a, busy_a}, 2'b10);
    chk("a_busy_cycles", cnt_busy, 4224);
    chk("a_reads",       cnt_re, 4096);
    chk("a_mac_en",      cnt_me, 4096);
    chk("a_coef_valid",  cnt_cv, 64);
    chk("a_mac_clr",     cnt_clr, 64);
    chk("a_addr_seq",    addr_err, 0);
    chk("a_coef_order",  order_err, 0);
    chk("a_clr_with_en", clr_err, 0);
    step();
    chk("a_done_pulse", done_a, 0);

    // Consumer stall on coefficient (0,2).
    start_a = 1; step(); start_a = 0;
    n = 0;
    while (!(cv_a && y_a == 3'd2) && n < 500) begin step(); n++; end
    chk("a_stall_reach", {cv_a, x_a, y_a}, {1'b1, 3'd0, 3'd2});
    rdy_a = 0; hold_err = 0;
    repeat (10) begin
      step();
      if (!(cv_a === 1'b1 && x_a === 3'd0 && y_a === 3'd2 && re_a === 1'b0 && busy_a === 1'b1))
        hold_err++;
    end
    chk("a_stall_hold", hold_err, 0);
    rdy_a = 1; step();
    chk("a_resume", {re_a, cv_a, address_a, x_a, y_a}, {1'b1, 1'b0, 6'd0, 3'd0, 3'd3});
    abort_a = 1; step(); abort_a = 0;
    chk("a_abort1_busy", busy_a, 0);

    // Abort on the 30th RUN cycle.
    start_a = 1; step(); start_a = 0;
    repeat (29) step();
    chk("a_abort_addr", {address_a, me_a}, {6'd29, 1'b1});
    abort_a = 1; start_a = 1; rdy_a = 1; step(); abort_a = 0; start_a = 0;
    chk("a_abort_state", {busy_a, re_a, me_a, mc_a, cv_a, done_a}, 0);
    quiet_err = 0;
    repeat (20) begin step(); if (done_a || busy_a) quiet_err++; end
    chk("a_abort_quiet", quiet_err, 0);

    // Asynchronous reset in the middle of DRAIN, then a fresh run.
    start_a = 1; step(); start_a = 0;
    repeat (64) step();
    chk("a_drain_pre", {busy_a, re_a, me_a, cv_a}, 4'b1010);
    #2 reset = 1'b1;
    #1;
    chk("a_rst_async_ctrl", {re_a, me_a, mc_a, cv_a, busy_a, done_a}, 0);
    chk("a_rst_async_idx",  {u_a, v_a, x_a, y_a, address_a}, 0);
    @(posedge clock); #2 reset = 1'b0;
    step();
    chk("a_post_rst_idle", {busy_a, done_a}, 0);
    start_a = 1; step(); start_a = 0;
    repeat (65) step();
    chk("a_rerun_first", {cv_a, x_a, y_a}, {1'b1, 3'd0, 3'd0});
    abort_a = 1; step(); abort_a = 0;

    // 2x2, RD_LAT=2 with start held high through done.
    start_b = 1; step();
    for (int s = 1; s <= 30; s++) begin
      chk($sformatf("b_trace_s%0d", s),
          {x_b, y_b, address_b, re_b, me_b, mc_b, cv_b, busy_b, done_b}, exp_b(s));
      if (s < 30) step();
    end
    start_b = 0; abort_b = 1; step(); abort_b = 0;
    chk("b_abort", {busy_b, me_b, done_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
